// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core MEM stage and a
// debug/load port. Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
// The core wins by default. The debug port is guaranteed a slot after STARVE_MAX
// consecutive core grants made while it was waiting.
//
// Handshake: a requester raises *_req with stable we/addr/wdata and holds it until
// its *_rvalid pulse. *_rvalid is high for exactly one cycle, and *_rdata is valid
// with it (0 for writes). A req that is still high in the rvalid cycle counts as a
// new request. Dropping req after the grant does not cancel the access.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [2:0]      WAIT_LOAD  = 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q,       state_d;
  logic            owner_dbg_q,   owner_dbg_d;
  logic            lat_we_q,      lat_we_d;
  logic [AW-1:0]   lat_addr_q,    lat_addr_d;
  logic [DW-1:0]   lat_wdata_q,   lat_wdata_d;
  logic [2:0]      wait_cnt_q,    wait_cnt_d;
  logic [SW-1:0]   starve_cnt_q,  starve_cnt_d;
  logic            mem_en_q,      mem_en_d;
  logic            mem_we_q,      mem_we_d;
  logic            dbg_gnt_q,     dbg_gnt_d;
  logic            core_rvalid_q, core_rvalid_d;
  logic            dbg_rvalid_q,  dbg_rvalid_d;
  logic [DW-1:0]   core_rdata_q,  core_rdata_d;
  logic [DW-1:0]   dbg_rdata_q,   dbg_rdata_d;
  logic            busy_q,        busy_d;
  logic [DW-1:0]   resp_data;
  logic            starve_full;

  assign starve_full = (starve_cnt_q == STARVE_LIM);

  // Next-state, grant decision and registered-output values for the access FSM.
  always_comb begin
    state_d       = state_q;
    owner_dbg_d   = owner_dbg_q;
    lat_we_d      = lat_we_q;
    lat_addr_d    = lat_addr_q;
    lat_wdata_d   = lat_wdata_q;
    wait_cnt_d    = wait_cnt_q;
    starve_cnt_d  = starve_cnt_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    dbg_gnt_d     = 1'b0;
    core_rvalid_d = 1'b0;
    dbg_rvalid_d  = 1'b0;
    core_rdata_d  = core_rdata_q;
    dbg_rdata_d   = dbg_rdata_q;
    resp_data     = '0;
    case (state_q)
      S_IDLE: begin
        if (dbg_req && (!core_req || starve_full)) begin
          state_d      = S_ISSUE;
          owner_dbg_d  = 1'b1;
          lat_we_d     = dbg_we;
          lat_addr_d   = dbg_addr;
          lat_wdata_d  = dbg_wdata;
          mem_en_d     = 1'b1;
          mem_we_d     = dbg_we;
          dbg_gnt_d    = 1'b1;
          starve_cnt_d = '0;
        end else if (core_req) begin
          state_d      = S_ISSUE;
          owner_dbg_d  = 1'b0;
          lat_we_d     = core_we;
          lat_addr_d   = core_addr;
          lat_wdata_d  = core_wdata;
          mem_en_d     = 1'b1;
          mem_we_d     = core_we;
          // Count only core grants that made a waiting debug request lose.
          if (!dbg_req) begin
            starve_cnt_d = '0;
          end else if (!starve_full) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
          end
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = WAIT_LOAD;
      end
      S_WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          // Last wait cycle: memory data is valid now, so load it straight
          // into the owner's rdata register for presentation in RESP.
          state_d   = S_RESP;
          resp_data = lat_we_q ? '0 : mem_rdata;
          if (owner_dbg_q) begin
            dbg_rvalid_d = 1'b1;
            dbg_rdata_d  = resp_data;
          end else begin
            core_rvalid_d = 1'b1;
            core_rdata_d  = resp_data;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops any in-flight access at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      owner_dbg_q   <= 1'b0;
      lat_we_q      <= 1'b0;
      lat_addr_q    <= '0;
      lat_wdata_q   <= '0;
      wait_cnt_q    <= '0;
      starve_cnt_q  <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      dbg_gnt_q     <= 1'b0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      dbg_rdata_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_dbg_q   <= owner_dbg_d;
      lat_we_q      <= lat_we_d;
      lat_addr_q    <= lat_addr_d;
      lat_wdata_q   <= lat_wdata_d;
      wait_cnt_q    <= wait_cnt_d;
      starve_cnt_q  <= starve_cnt_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      dbg_gnt_q     <= dbg_gnt_d;
      core_rvalid_q <= core_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      dbg_rdata_q   <= dbg_rdata_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = lat_addr_q;
  assign mem_wdata   = lat_wdata_q;
  assign dbg_gnt     = dbg_gnt_q;
  assign core_rvalid = core_rvalid_q;
  assign dbg_rvalid  = dbg_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign dbg_rdata   = dbg_rdata_q;
  assign busy        = busy_q;
  assign core_stall  = core_req & ~core_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a cycle-arithmetic reference model.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 3;
  localparam int SM = 4;
  localparam int P  = ML + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, core_stall, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(ML), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  logic [DW-1:0] held_core = '0;
  logic [DW-1:0] held_dbg  = '0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          dbg;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            issue;
    int            resp;
  } acc_t;
  acc_t acc_q[$];

  typedef struct {
    logic          core_req, dbg_req, core_we, dbg_we;
    logic [AW-1:0] core_addr, dbg_addr;
    logic [DW-1:0] core_wdata, dbg_wdata, mem_data;
    logic          exp_dbg, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tg);
    chk({tg, "_mem_en"}, mem_en, 0);
    chk({tg, "_mem_we"}, mem_we, 0);
    chk({tg, "_mem_addr"}, mem_addr, 0);
    chk({tg, "_mem_wdata"}, mem_wdata, 0);
    chk({tg, "_core_rvalid"}, core_rvalid, 0);
    chk({tg, "_dbg_rvalid"}, dbg_rvalid, 0);
    chk({tg, "_core_rdata"}, core_rdata, 0);
    chk({tg, "_dbg_rdata"}, dbg_rdata, 0);
    chk({tg, "_dbg_gnt"}, dbg_gnt, 0);
    chk({tg, "_busy"}, busy, 0);
  endtask

  // One complete access from an idle arbiter, checked cycle by cycle.
  task automatic apply_vec(input vec_t v, input int idx);
    string tg;
    tg = $sformatf("vec%0d", idx);
    next_cycle();
    core_req = v.core_req; core_we = v.core_we; core_addr = v.core_addr;
    core_wdata = v.core_wdata;
    dbg_req = v.dbg_req; dbg_we = v.dbg_we; dbg_addr = v.dbg_addr; dbg_wdata = v.dbg_wdata;
    mem_rdata = $urandom;
    sample();
    chk({tg, "_idle_stall"}, core_stall, v.core_req);
    chk({tg, "_idle_busy"}, busy, 0);
    chk({tg, "_idle_mem_en"}, mem_en, 0);
    next_cycle();
    mem_rdata = $urandom;
    sample();
    chk({tg, "_issue_mem_en"}, mem_en, 1);
    chk({tg, "_issue_mem_we"}, mem_we, v.exp_we);
    chk({tg, "_issue_mem_addr"}, mem_addr, v.exp_addr);
    chk({tg, "_issue_mem_wdata"}, mem_wdata, v.exp_wdata);
    chk({tg, "_issue_dbg_gnt"}, dbg_gnt, v.exp_dbg);
    chk({tg, "_issue_busy"}, busy, 1);
    for (int i = 1; i <= ML; i++) begin
      next_cycle();
      mem_rdata = (i == ML) ? v.mem_data : $urandom;
      sample();
      chk({tg, "_wait_mem_en"}, mem_en, 0);
      chk({tg, "_wait_core_rvalid"}, core_rvalid, 0);
      chk({tg, "_wait_dbg_rvalid"}, dbg_rvalid, 0);
      chk({tg, "_wait_stall"}, core_stall, v.core_req);
    end
    next_cycle();
    mem_rdata = $urandom;
    sample();
    if (v.exp_dbg) held_dbg = v.exp_rdata;
    else held_core = v.exp_rdata;
    chk({tg, "_resp_core_rvalid"}, core_rvalid, !v.exp_dbg);
    chk({tg, "_resp_dbg_rvalid"}, dbg_rvalid, v.exp_dbg);
    chk({tg, "_resp_core_rdata"}, core_rdata, held_core);
    chk({tg, "_resp_dbg_rdata"}, dbg_rdata, held_dbg);
    chk({tg, "_resp_stall"}, core_stall, v.core_req & v.exp_dbg);
    chk({tg, "_resp_busy"}, busy, 1);
    next_cycle();
    core_req = 1'b0;
    dbg_req  = 1'b0;
    sample();
    chk({tg, "_after_rvalid"}, {core_rvalid, dbg_rvalid}, 0);
    chk({tg, "_after_busy"}, busy, 0);
    chk({tg, "_after_core_rdata"}, core_rdata, held_core);
    chk({tg, "_after_dbg_rdata"}, dbg_rdata, held_dbg);
  endtask

  // ---------------- main test ----------------
  int            s, gnts, k, free_cyc, starve, resp_at;
  logic          exp_d, has, exp_en, exp_crv, exp_drv, core_seen, dbg_seen;
  logic [AW-1:0] resp_addr;
  logic [DW-1:0] d, v1, v2;
  acc_t          h, a;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF,
                1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1234, 32'h0, 32'hFFFF0000,
                1'b0, 1'b1, 32'h20, 32'h1234, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0, 32'h77, 32'hCAFEF00D,
                1'b1, 1'b0, 32'h40, 32'h77, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h44, 32'h0, 32'hA5A5A5A5, 32'h11111111,
                1'b1, 1'b1, 32'h44, 32'hA5A5A5A5, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h90, 32'h5, 32'h6, 32'h0BADF00D,
                1'b0, 1'b0, 32'h80, 32'h5, 32'h0BADF00D};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h22222222,
                1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h80000001,
                1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h80000001};

    reset = 1'b0;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_stall", core_stall, 0);
    reset = 1'b1;

    // Directed single-access vectors.
    for (int i = 0; i < 7; i++) apply_vec(vecs[i], i);

    // Both requesters held high: bounded-priority grant order.
    next_cycle();
    s = cyc;
    core_req = 1; core_we = 1; core_addr = 32'hC0; core_wdata = 32'h99;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'hD0; dbg_wdata = 32'h55;
    gnts = 0;
    for (int i = 0; i < 10 * P; i++) begin
      if (i > 0) next_cycle();
      mem_rdata = $urandom;
      sample();
      k = i / P;
      exp_d = ((k % (SM + 1)) == SM);
      if ((i % P) == 1) begin
        chk($sformatf("fair_grant%0d_mem_en", k), mem_en, 1);
        chk($sformatf("fair_grant%0d_dbg_gnt", k), dbg_gnt, exp_d);
        chk($sformatf("fair_grant%0d_addr", k), mem_addr, exp_d ? 32'hD0 : 32'hC0);
      end else begin
        chk("fair_gap_mem_en", mem_en, 0);
      end
      chk("fair_core_rvalid", core_rvalid, ((i % P) == P - 1) && !exp_d);
      chk("fair_dbg_rvalid", dbg_rvalid, ((i % P) == P - 1) && exp_d);
      if (dbg_gnt) gnts++;
    end
    next_cycle();
    core_req = 0; dbg_req = 0;
    sample();
    chk("fair_gnt_count", gnts, 10 / (SM + 1));
    chk("fair_end_busy", busy, 0);
    held_core = '0;
    held_dbg  = '0;

    // Core drops its request after the grant; pending dbg wins the next IDLE.
    v1 = 32'h600DCAFE;
    v2 = 32'h0FEEDBAC;
    next_cycle();
    s = cyc;
    core_req = 1; core_we = 0; core_addr = 32'h100;
    sample();
    chk("drop_idle_stall", core_stall, 1);
    next_cycle();
    core_req = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h200; dbg_wdata = 32'h0;
    sample();
    chk("drop_issue_mem_en", mem_en, 1);
    chk("drop_issue_addr", mem_addr, 32'h100);
    chk("drop_issue_gnt", dbg_gnt, 0);
    chk("drop_issue_stall", core_stall, 0);
    for (int i = 1; i <= ML; i++) begin
      next_cycle();
      mem_rdata = (i == ML) ? v1 : $urandom;
      sample();
      chk("drop_wait_rvalid", {core_rvalid, dbg_rvalid}, 0);
    end
    next_cycle();
    mem_rdata = $urandom;
    sample();
    chk("drop_core_rvalid_cycle", cyc - s, 2 + ML);
    chk("drop_core_rvalid", core_rvalid, 1);
    chk("drop_core_rdata", core_rdata, v1);
    chk("drop_dbg_rvalid", dbg_rvalid, 0);
    held_core = v1;
    next_cycle();
    sample();
    chk("drop_idle2_mem_en", mem_en, 0);
    chk("drop_idle2_busy", busy, 0);
    next_cycle();
    sample();
    chk("drop_dbg_issue_mem_en", mem_en, 1);
    chk("drop_dbg_issue_gnt", dbg_gnt, 1);
    chk("drop_dbg_issue_addr", mem_addr, 32'h200);
    for (int i = 1; i <= ML; i++) begin
      next_cycle();
      mem_rdata = (i == ML) ? v2 : $urandom;
      sample();
    end
    next_cycle();
    sample();
    chk("drop_dbg_rvalid", dbg_rvalid, 1);
    chk("drop_dbg_rdata", dbg_rdata, v2);
    chk("drop_dbg_core_rdata_held", core_rdata, v1);
    held_dbg = v2;
    next_cycle();
    dbg_req = 0;
    sample();

    // Reset in the WAIT phase of a core read.
    next_cycle();
    core_req = 1; core_we = 0; core_addr = 32'h300; core_wdata = 32'h0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    chk("midreset_stall", core_stall, 1);
    core_req = 0;
    held_core = '0;
    held_dbg  = '0;
    next_cycle();
    sample();
    chk_all_zero("midreset_hold");
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < P; i++) begin
      sample();
      chk("postreset_core_rvalid", core_rvalid, 0);
      chk("postreset_mem_en", mem_en, 0);
      chk("postreset_busy", busy, 0);
      next_cycle();
    end
    sample();
    vecs[0].core_addr = 32'h300;
    vecs[0].exp_addr  = 32'h300;
    apply_vec(vecs[0], 7);

    // Randomized traffic against the reference model.
    free_cyc = cyc + 1;
    starve = 0;
    resp_at = -1;
    resp_addr = '0;
    core_seen = 0;
    dbg_seen = 0;
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if (!core_req) begin
        if ($urandom_range(0, 99) < 40) begin
          core_req = 1; core_we = 1'($urandom_range(0, 1));
          core_addr = $urandom; core_wdata = $urandom;
        end
      end else if (core_seen) begin
        if ($urandom_range(0, 1) == 0) core_req = 0;
        else begin
          core_we = 1'($urandom_range(0, 1)); core_addr = $urandom; core_wdata = $urandom;
        end
      end else if ($urandom_range(0, 99) < 3) core_req = 0;
      if (!dbg_req) begin
        if ($urandom_range(0, 99) < 40) begin
          dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
          dbg_addr = $urandom; dbg_wdata = $urandom;
        end
      end else if (dbg_seen) begin
        if ($urandom_range(0, 1) == 0) dbg_req = 0;
        else begin
          dbg_we = 1'($urandom_range(0, 1)); dbg_addr = $urandom; dbg_wdata = $urandom;
        end
      end else if ($urandom_range(0, 99) < 3) dbg_req = 0;
      mem_rdata = (cyc == resp_at) ? mem_val(resp_addr) : $urandom;

      if (cyc == free_cyc) begin
        if (dbg_req && (!core_req || starve == SM)) begin
          a = '{1'b1, dbg_we, dbg_addr, dbg_wdata, cyc + 1, cyc + 2 + ML};
          acc_q.push_back(a);
          exp_q.push_back(dbg_we ? '0 : mem_val(dbg_addr));
          starve = 0;
          free_cyc = cyc + P;
        end else if (core_req) begin
          a = '{1'b0, core_we, core_addr, core_wdata, cyc + 1, cyc + 2 + ML};
          acc_q.push_back(a);
          exp_q.push_back(core_we ? '0 : mem_val(core_addr));
          starve = dbg_req ? ((starve < SM) ? starve + 1 : SM) : 0;
          free_cyc = cyc + P;
        end else begin
          free_cyc = cyc + 1;
        end
      end

      sample();
      has = (acc_q.size() > 0);
      if (has) h = acc_q[0];
      exp_en  = has && (h.issue == cyc);
      exp_crv = has && (h.resp == cyc) && !h.dbg;
      exp_drv = has && (h.resp == cyc) && h.dbg;
      chk("rnd_mem_en", mem_en, exp_en);
      if (exp_en) begin
        chk("rnd_mem_we", mem_we, h.we);
        chk("rnd_mem_addr", mem_addr, h.addr);
        chk("rnd_mem_wdata", mem_wdata, h.wdata);
      end
      chk("rnd_dbg_gnt", dbg_gnt, exp_en && h.dbg);
      chk("rnd_busy", busy, has && (cyc >= h.issue) && (cyc <= h.resp));
      chk("rnd_core_rvalid", core_rvalid, exp_crv);
      chk("rnd_dbg_rvalid", dbg_rvalid, exp_drv);
      chk("rnd_core_stall", core_stall, core_req & ~exp_crv);
      if (exp_crv || exp_drv) begin
        d = exp_q.pop_front();
        if (h.dbg) held_dbg = d;
        else held_core = d;
        void'(acc_q.pop_front());
      end
      chk("rnd_core_rdata", core_rdata, held_core);
      chk("rnd_dbg_rdata", dbg_rdata, held_dbg);
      if (mem_en) begin
        resp_at = cyc + ML;
        resp_addr = mem_addr;
      end
      core_seen = core_rvalid;
      dbg_seen = dbg_rvalid;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
